// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: word prefetch FIFO, 16/32-bit realignment and redirect handling.
// state | meaning: FETCH = normal prefetch into the FIFO; DRAIN = finish an orphaned bus read, discard it.
module fetch_prefetch_buffer #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int unsigned DEPTH         = 4,
    parameter bit          COMPRESSED_EN = 1'b1
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    input  logic                         inst_ready_i,
    output logic                         inst_valid_o,
    output logic [31:0]                  inst_o,
    output logic [31:0]                  inst_pc_o,
    output logic [31:0]                  inst_npc_o,
    output logic                         inst_compressed_o,
    output logic                         fault_o,
    output logic [31:0]                  fault_addr_o,
    output logic [31:0]                  mem_addr_o,
    output logic                         mem_ren_o,
    input  logic [31:0]                  mem_rdata_i,
    input  logic                         mem_busy_i,
    output logic [$clog2(DEPTH+1)-1:0]   buffer_count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc;
    logic [31:0]     faddr;
    logic [31:0]     faddr_next;
    logic            fault;
    logic [31:0]     fault_addr;
    logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr_nx;
    logic [CW-1:0]   count;
    logic [31:0]     fifo_mem [DEPTH];

    logic [31:0]     head_word, next_word;
    logic [15:0]     half;
    logic            compressed;
    logic            valid;
    logic            complete, in_flight;
    logic            accept, push, pop;
    logic            misaligned;
    logic [31:0]     target_aligned;

    assign rd_ptr_nx  = rd_ptr + AW'(1);
    assign head_word  = fifo_mem[rd_ptr];
    assign next_word  = fifo_mem[rd_ptr_nx];
    assign half       = pc[1] ? head_word[31:16] : head_word[15:0];
    assign compressed = COMPRESSED_EN && (half[1:0] != 2'b11);

    // A 32-bit instruction in the upper half spans into the following word.
    always_comb begin
        valid = 1'b0;
        if (!fault) begin
            if (compressed || !pc[1]) valid = (count >= CW'(1));
            else                      valid = (count >= CW'(2));
        end
    end

    always_comb begin
        inst_o = head_word;
        if (compressed)  inst_o = {16'h0000, half};
        else if (pc[1])  inst_o = {next_word[15:0], head_word[31:16]};
    end

    assign inst_valid_o      = valid;
    assign inst_pc_o         = pc;
    assign inst_npc_o        = pc + (compressed ? 32'd2 : 32'd4);
    assign inst_compressed_o = compressed;

    assign mem_ren_o = (state_q == DRAIN) ||
                       ((state_q == FETCH) && (count < CW'(DEPTH)) && !fault);
    assign mem_addr_o     = faddr;
    assign complete       = mem_ren_o && !mem_busy_i;
    assign in_flight      = mem_ren_o && mem_busy_i;
    assign accept         = valid && inst_ready_i && !redirect_i;
    assign push           = complete && (state_q == FETCH) && !redirect_i;
    assign pop            = accept && !(compressed && !pc[1]);
    assign misaligned     = redirect_pc_i[0] || (!COMPRESSED_EN && redirect_pc_i[1]);
    assign target_aligned = {redirect_pc_i[31:2], 2'b00};

    assign fault_o        = fault;
    assign fault_addr_o   = fault_addr;
    assign buffer_count_o = count;

    always_comb begin
        state_d = state_q;
        if (redirect_i)                          state_d = in_flight ? DRAIN : FETCH;
        else if (state_q == DRAIN && complete)   state_d = FETCH;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc         <= RESET_PC;
            faddr      <= RESET_PC;
            faddr_next <= RESET_PC;
            fault      <= 1'b0;
            fault_addr <= 32'h0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else if (redirect_i) begin
            pc     <= redirect_pc_i;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fault  <= misaligned;
            if (misaligned) fault_addr <= redirect_pc_i;
            // An in-flight read cannot be aborted; park the target until it drains.
            if (in_flight) faddr_next <= target_aligned;
            else           faddr      <= target_aligned;
        end else begin
            if (state_q == DRAIN) begin
                if (complete) faddr <= faddr_next;
            end else if (complete) begin
                faddr  <= faddr + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (accept) pc <= inst_npc_o;
            if (pop)    rd_ptr <= rd_ptr_nx;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata_i;
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: a vector table for the reset/backpressure stream
// plus hand-written sequences for realignment, drain, wrap-around and faults.
module tb_fetch_prefetch_buffer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic nRST;

    // dut0: COMPRESSED_EN=1, dut1: COMPRESSED_EN=0
    logic        redirect0, ready0, busy0, mixed;
    logic [31:0] redirect_pc0, rdata0;
    logic        valid0, comp0, fault0, ren0;
    logic [31:0] inst0, pc0, npc0, fault_addr0, addr0;
    logic [2:0]  count0;

    logic        redirect1, ready1, busy1;
    logic [31:0] redirect_pc1, rdata1;
    logic        valid1, comp1, fault1, ren1;
    logic [31:0] inst1, pc1, npc1, fault_addr1, addr1;
    logic [2:0]  count1;

    int checks = 0;
    int errors = 0;

    // Default memory image: each word is a 32-bit instruction encoding its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic mix);
        if (mix && a == 32'h8000_0000) return 32'h0513_0001;
        if (mix && a == 32'h8000_0004) return 32'h0000_00A0;
        return {a[31:2], 2'b11};
    endfunction

    assign rdata0 = mem_word(addr0, mixed);
    assign rdata1 = mem_word(addr1, 1'b0);

    fetch_prefetch_buffer #(.RESET_PC(32'h8000_0000), .DEPTH(4), .COMPRESSED_EN(1'b1)) dut0 (
        .CLK(CLK), .nRST(nRST),
        .redirect_i(redirect0), .redirect_pc_i(redirect_pc0), .inst_ready_i(ready0),
        .inst_valid_o(valid0), .inst_o(inst0), .inst_pc_o(pc0), .inst_npc_o(npc0),
        .inst_compressed_o(comp0), .fault_o(fault0), .fault_addr_o(fault_addr0),
        .mem_addr_o(addr0), .mem_ren_o(ren0), .mem_rdata_i(rdata0), .mem_busy_i(busy0),
        .buffer_count_o(count0)
    );

    fetch_prefetch_buffer #(.RESET_PC(32'h8000_0000), .DEPTH(4), .COMPRESSED_EN(1'b0)) dut1 (
        .CLK(CLK), .nRST(nRST),
        .redirect_i(redirect1), .redirect_pc_i(redirect_pc1), .inst_ready_i(ready1),
        .inst_valid_o(valid1), .inst_o(inst1), .inst_pc_o(pc1), .inst_npc_o(npc1),
        .inst_compressed_o(comp1), .fault_o(fault1), .fault_addr_o(fault_addr1),
        .mem_addr_o(addr1), .mem_ren_o(ren1), .mem_rdata_i(rdata1), .mem_busy_i(busy1),
        .buffer_count_o(count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_inst(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic comp);
        chk({tag, " valid"}, 32'(valid0), 32'd1);
        chk({tag, " pc"}, pc0, pc);
        chk({tag, " inst"}, inst0, inst);
        chk({tag, " npc"}, npc0, pc + (comp ? 32'd2 : 32'd4));
        chk({tag, " compressed"}, 32'(comp0), 32'(comp));
    endtask

    typedef struct {
        logic        ready;
        logic        v;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ren;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // k = cycles after reset release; release happens between edges
        tbl[0]  = '{1'b1, 1'b0, 32'h0,         3'd0, 1'b1, 32'h8000_0000};
        tbl[1]  = '{1'b1, 1'b1, 32'h8000_0000, 3'd1, 1'b1, 32'h8000_0004};
        tbl[2]  = '{1'b1, 1'b1, 32'h8000_0004, 3'd1, 1'b1, 32'h8000_0008};
        tbl[3]  = '{1'b0, 1'b1, 32'h8000_0008, 3'd1, 1'b1, 32'h8000_000C};
        tbl[4]  = '{1'b0, 1'b1, 32'h8000_0008, 3'd2, 1'b1, 32'h8000_0010};
        tbl[5]  = '{1'b0, 1'b1, 32'h8000_0008, 3'd3, 1'b1, 32'h8000_0014};
        for (int k = 6; k <= 12; k++)
            tbl[k] = '{1'b0, 1'b1, 32'h8000_0008, 3'd4, 1'b0, 32'h8000_0018};
        tbl[13] = '{1'b1, 1'b1, 32'h8000_0008, 3'd4, 1'b0, 32'h8000_0018};
        tbl[14] = '{1'b1, 1'b1, 32'h8000_000C, 3'd3, 1'b1, 32'h8000_0018};
        tbl[15] = '{1'b1, 1'b1, 32'h8000_0010, 3'd3, 1'b1, 32'h8000_001C};
        tbl[16] = '{1'b1, 1'b1, 32'h8000_0014, 3'd3, 1'b1, 32'h8000_0020};

        nRST = 1'b0;
        redirect0 = 1'b0; redirect_pc0 = 32'h0; ready0 = 1'b1; busy0 = 1'b0; mixed = 1'b0;
        redirect1 = 1'b0; redirect_pc1 = 32'h0; ready1 = 1'b1; busy1 = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset fault", 32'(fault0), 32'd0);
        chk("reset fault_addr", fault_addr0, 32'h0);
        chk("reset valid", 32'(valid0), 32'd0);
        chk("reset ren", 32'(ren0), 32'd1);
        chk("reset addr", addr0, 32'h8000_0000);
        @(negedge CLK);
        nRST = 1'b1;

        for (int k = 0; k < 17; k++) begin
            ready0 = tbl[k].ready;
            #1;
            chk($sformatf("stream[%0d] valid", k), 32'(valid0), 32'(tbl[k].v));
            chk($sformatf("stream[%0d] count", k), 32'(count0), 32'(tbl[k].cnt));
            chk($sformatf("stream[%0d] ren", k), 32'(ren0), 32'(tbl[k].ren));
            chk($sformatf("stream[%0d] addr", k), addr0, tbl[k].addr);
            if (tbl[k].v)
                exp_inst($sformatf("stream[%0d]", k), tbl[k].pc,
                         {tbl[k].pc[31:2], 2'b11}, 1'b0);
            @(negedge CLK);
        end

        // Mixed compressed + spanning 32-bit instruction
        mixed = 1'b1; ready0 = 1'b1;
        redirect0 = 1'b1; redirect_pc0 = 32'h8000_0000;
        @(negedge CLK);
        redirect0 = 1'b0; #1;
        chk("mix latency valid", 32'(valid0), 32'd0);
        chk("mix req addr", addr0, 32'h8000_0000);
        chk("mix count flushed", 32'(count0), 32'd0);
        @(negedge CLK); #1;
        exp_inst("mix c16", 32'h8000_0000, 32'h0000_0001, 1'b1);
        @(negedge CLK); #1;
        exp_inst("mix span", 32'h8000_0002, 32'h00A0_0513, 1'b0);
        chk("mix span count", 32'(count0), 32'd2);
        @(negedge CLK);

        // Redirect while a transfer is stalled: 3 busy cycles
        mixed = 1'b0; busy0 = 1'b1;
        redirect0 = 1'b1; redirect_pc0 = 32'h8000_0100;
        #1;
        chk("drain start addr", addr0, 32'h8000_000C);
        chk("drain start ren", 32'(ren0), 32'd1);
        @(negedge CLK);
        redirect0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("drain hold[%0d] addr", i), addr0, 32'h8000_000C);
            chk($sformatf("drain hold[%0d] ren", i), 32'(ren0), 32'd1);
            chk($sformatf("drain hold[%0d] valid", i), 32'(valid0), 32'd0);
            @(negedge CLK);
        end
        busy0 = 1'b0; #1;
        chk("drain last addr", addr0, 32'h8000_000C);
        @(negedge CLK); #1;
        chk("drain discard count", 32'(count0), 32'd0);
        chk("drain new addr", addr0, 32'h8000_0100);
        chk("drain new ren", 32'(ren0), 32'd1);
        @(negedge CLK); #1;
        exp_inst("drain first", 32'h8000_0100, 32'h8000_0103, 1'b0);
        @(negedge CLK);

        // Wrap-around at the top of the address space
        redirect0 = 1'b1; redirect_pc0 = 32'hFFFF_FFFC;
        @(negedge CLK);
        redirect0 = 1'b0; #1;
        chk("wrap req addr", addr0, 32'hFFFF_FFFC);
        @(negedge CLK); #1;
        exp_inst("wrap top", 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0);
        chk("wrap next addr", addr0, 32'h0000_0000);
        @(negedge CLK); #1;
        exp_inst("wrap zero", 32'h0000_0000, 32'h0000_0003, 1'b0);
        @(negedge CLK);

        // Halfword target is legal with compression: upper half 0x8000 is a 16-bit op
        redirect0 = 1'b1; redirect_pc0 = 32'h8000_0102;
        @(negedge CLK);
        redirect0 = 1'b0; #1;
        chk("half req addr", addr0, 32'h8000_0100);
        @(negedge CLK); #1;
        exp_inst("half c16", 32'h8000_0102, 32'h0000_8000, 1'b1);
        @(negedge CLK);

        // Odd target faults even with compression enabled
        redirect0 = 1'b1; redirect_pc0 = 32'h8000_0001;
        @(negedge CLK);
        redirect0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("odd fault[%0d]", i), 32'(fault0), 32'd1);
            chk($sformatf("odd fault_addr[%0d]", i), fault_addr0, 32'h8000_0001);
            chk($sformatf("odd valid[%0d]", i), 32'(valid0), 32'd0);
            chk($sformatf("odd ren[%0d]", i), 32'(ren0), 32'd0);
            @(negedge CLK);
        end
        redirect0 = 1'b1; redirect_pc0 = 32'h8000_0200;
        @(negedge CLK);
        redirect0 = 1'b0; #1;
        chk("odd clear fault", 32'(fault0), 32'd0);
        chk("odd resume ren", 32'(ren0), 32'd1);
        chk("odd resume addr", addr0, 32'h8000_0200);
        @(negedge CLK); #1;
        exp_inst("odd resume", 32'h8000_0200, 32'h8000_0203, 1'b0);
        @(negedge CLK);

        // Halfword target faults without compression
        redirect1 = 1'b1; redirect_pc1 = 32'h8000_0102;
        @(negedge CLK);
        redirect1 = 1'b0; #1;
        chk("nc fault", 32'(fault1), 32'd1);
        chk("nc fault_addr", fault_addr1, 32'h8000_0102);
        chk("nc valid", 32'(valid1), 32'd0);
        chk("nc ren", 32'(ren1), 32'd0);
        @(negedge CLK);
        redirect1 = 1'b1; redirect_pc1 = 32'h8000_0200;
        @(negedge CLK);
        redirect1 = 1'b0; #1;
        chk("nc clear fault", 32'(fault1), 32'd0);
        chk("nc resume ren", 32'(ren1), 32'd1);
        chk("nc resume addr", addr1, 32'h8000_0200);
        chk("nc resume count", 32'(count1), 32'd0);
        @(negedge CLK); #1;
        chk("nc first valid", 32'(valid1), 32'd1);
        chk("nc first pc", pc1, 32'h8000_0200);
        chk("nc first inst", inst1, 32'h8000_0203);
        chk("nc first npc", npc1, 32'h8000_0204);
        chk("nc first compressed", 32'(comp1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
